pmu_sequencer: RTL and testbench

- Front-end controller for the power manager. It arbitrates clock-change requests from two requesters (CPU I/O port decoder and UART command decoder) and validates each request vector.
- Each accepted request becomes a single-cycle change/change_vector pulse to the power manager, followed by a settle hold-off. Back-to-back reconfiguration of the clock muxes is therefore impossible.
- It also sequences automatic sleep after an idle timeout and the return to run mode on a wake input.
- Sits between the request sources and the power manager, in the 12 MHz clk domain.

---
 rtl/pmu_seq_if.sv | 26 ++
 rtl/pmu_sequencer.sv | 138 +++++++++++++
 tb/tb_pmu_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pmu_seq_if.sv
// Request/strobe bundle between the clock-change requesters, the wake source
// and the power-manager front end.
interface pmu_seq_if;
  logic       req0;
  logic [7:0] vec0;
  logic       ack0;
  logic       req1;
  logic [7:0] vec1;
  logic       ack1;
  logic       wake;
  logic       change;
  logic [7:0] change_vector;
  logic       err;
  logic       busy;
  logic       asleep;

  modport master (
    output req0, vec0, req1, vec1, wake,
    input  ack0, ack1, change, change_vector, err, busy, asleep
  );

  modport slave (
    input  req0, vec0, req1, vec1, wake,
    output ack0, ack1, change, change_vector, err, busy, asleep
  );
endinterface

// File: rtl/pmu_sequencer.sv
// Power-manager front end: round-robin arbitration of two clock-change
// requesters, vector validation, settle hold-off, and idle auto-sleep/wake.
module pmu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned IDLE_TIMEOUT  = 12000000,
  parameter logic [7:0]  SLEEP_VECTOR  = 8'hE3,
  parameter logic [7:0]  WAKE_VECTOR   = 8'hE1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  pmu_seq_if.slave   bus
);

  localparam int unsigned  CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [23:0]   TO_LAST     = 24'(IDLE_TIMEOUT - 1);
  localparam logic          AUTO_SLEEP  = (IDLE_TIMEOUT != 0);

  typedef enum logic {S_IDLE, S_SETTLE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   idle_q, idle_d;
  logic          rr_q, rr_d;
  logic          change_q, change_d;
  logic [7:0]    vec_q, vec_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic          asleep_q, asleep_d;

  logic       wake_go, any_req, gnt0, gnt1, vec_ok, timeout_hit, issue;
  logic [7:0] sel_vec;

  // rr_q=1 hands a tie to requester 1; it always points away from the last grant.
  assign wake_go     = bus.wake & asleep_q;
  assign any_req     = bus.req0 | bus.req1;
  assign gnt1        = bus.req1 & (~bus.req0 | rr_q);
  assign gnt0        = bus.req0 & ~gnt1;
  assign sel_vec     = gnt1 ? bus.vec1 : bus.vec0;
  assign vec_ok      = (sel_vec[7:5] != 3'b000) && (sel_vec[2:0] <= 3'b100);
  assign timeout_hit = AUTO_SLEEP && !asleep_q && (idle_q == TO_LAST);
  assign issue       = (state_q == S_IDLE) &&
                       (wake_go || (any_req ? vec_ok : timeout_hit));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (issue) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    change_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    vec_d    = vec_q;
    asleep_d = asleep_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    case (state_q)
      S_IDLE: begin
        if (wake_go) begin
          change_d = 1'b1;
          vec_d    = WAKE_VECTOR;
          asleep_d = 1'b0;
          idle_d   = '0;
        end else if (any_req) begin
          ack0_d = gnt0;
          ack1_d = gnt1;
          rr_d   = gnt0;
          idle_d = '0;
          if (vec_ok) begin
            change_d = 1'b1;
            vec_d    = sel_vec;
            asleep_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          change_d = 1'b1;
          vec_d    = SLEEP_VECTOR;
          asleep_d = 1'b1;
        end else if (!asleep_q && !bus.wake && (idle_q != '1)) begin
          idle_d = idle_q + 24'd1;
        end
        if (issue) cnt_d = SETTLE_LOAD;
      end
      S_SETTLE: begin
        idle_d = '0;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q    <= '0;
      idle_q   <= '0;
      rr_q     <= 1'b0;
      change_q <= 1'b0;
      vec_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      asleep_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      rr_q     <= rr_d;
      change_q <= change_d;
      vec_q    <= vec_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      asleep_q <= asleep_d;
    end
  end

  assign bus.change        = change_q;
  assign bus.change_vector = vec_q;
  assign bus.ack0          = ack0_q;
  assign bus.ack1          = ack1_q;
  assign bus.err           = err_q;
  assign bus.asleep        = asleep_q;
  assign bus.busy          = (state_q == S_SETTLE);

endmodule

// File: tb/tb_pmu_sequencer.sv
// Directed bench for pmu_sequencer with a short idle timeout so auto-sleep
// is reachable; strobes are packed as {ack0, ack1, err, change, busy, asleep}.
module tb_pmu_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  pmu_seq_if bus();

  pmu_sequencer #(
    .SETTLE_CYCLES(16),
    .IDLE_TIMEOUT (100),
    .SLEEP_VECTOR (8'hE3),
    .WAKE_VECTOR  (8'hE1)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] st;
  assign st = {bus.ack0, bus.ack1, bus.err, bus.change, bus.busy, bus.asleep};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wake = 1'b0;
    bus.vec0 = 8'h00; bus.vec1 = 8'h00;
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk(tag, {18'd0, st, bus.change_vector}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;

    // 1: single request, latency and settle length
    do_reset("t1_reset");
    bus.req0 = 1'b1; bus.vec0 = 8'h81;
    tick();
    chk("t1_grant", st, 6'b100110);
    chk("t1_vec", bus.change_vector, 8'h81);
    bus.req0 = 1'b0;
    tick();
    chk("t1_strobe_width", st, 6'b000010);
    quiet = 0;
    repeat (14) begin
      tick();
      if (bus.busy && !bus.change) quiet++;
    end
    chk("t1_busy_cycles", quiet, 14);
    tick();
    chk("t1_settle_end", st, 6'b000000);

    // 2: tie, round-robin alternation 17 cycles apart
    do_reset("t2_reset");
    bus.req0 = 1'b1; bus.vec0 = 8'h22;
    bus.req1 = 1'b1; bus.vec1 = 8'h44;
    tick();
    chk("t2_grant0", st, 6'b100110);
    chk("t2_vec0", bus.change_vector, 8'h22);
    for (int g = 1; g <= 3; g++) begin
      quiet = 0;
      repeat (16) begin
        tick();
        if (bus.change || bus.ack0 || bus.ack1) quiet++;
      end
      chk("t2_quiet", quiet, 0);
      tick();
      if (g % 2 == 1) begin
        chk("t2_grant_r1", st, 6'b010110);
        chk("t2_vec_r1", bus.change_vector, 8'h44);
      end else begin
        chk("t2_grant_r0", st, 6'b100110);
        chk("t2_vec_r0", bus.change_vector, 8'h22);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle("t2_idle");

    // 3: rejected vectors hold change_vector; pointer still advances
    bus.req1 = 1'b1; bus.vec1 = 8'h87;
    tick();
    chk("t3_bad_mode", st, 6'b011000);
    chk("t3_vec_hold_a", bus.change_vector, 8'h44);
    bus.req1 = 1'b0;
    tick();
    chk("t3_err_width", st, 6'b000000);
    bus.req1 = 1'b1; bus.vec1 = 8'h04;
    tick();
    chk("t3_no_sel", st, 6'b011000);
    chk("t3_vec_hold_b", bus.change_vector, 8'h44);
    bus.req1 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.vec0 = 8'h05;
    tick();
    chk("t3_bad_r0", st, 6'b101000);
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.vec0 = 8'h22;
    bus.req1 = 1'b1; bus.vec1 = 8'h62;
    tick();
    chk("t3_rr_after_err", st, 6'b010110);
    chk("t3_rr_vec", bus.change_vector, 8'h62);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle("t3_idle");

    // 4: auto-sleep at cycle 100, no re-trigger, wake
    do_reset("t4_reset");
    quiet = 0;
    repeat (99) begin
      tick();
      if (bus.change) quiet++;
    end
    chk("t4_no_early_sleep", quiet, 0);
    tick();
    chk("t4_sleep", st, 6'b000111);
    chk("t4_sleep_vec", bus.change_vector, 8'hE3);
    wait_idle("t4_idle");
    quiet = 0;
    repeat (120) begin
      tick();
      if (bus.change) quiet++;
    end
    chk("t4_no_retrigger", quiet, 0);
    chk("t4_still_asleep", {31'd0, bus.asleep}, 32'd1);
    bus.wake = 1'b1;
    tick();
    chk("t4_wake", st, 6'b000110);
    chk("t4_wake_vec", bus.change_vector, 8'hE1);
    bus.wake = 1'b0;
    wait_idle("t4_idle2");

    // 5: wake and request together while asleep
    do_reset("t5_reset");
    repeat (100) tick();
    chk("t5_asleep", {31'd0, bus.asleep}, 32'd1);
    wait_idle("t5_idle");
    bus.wake = 1'b1; bus.req0 = 1'b1; bus.vec0 = 8'h81;
    tick();
    chk("t5_wake_only", st, 6'b000110);
    chk("t5_wake_vec", bus.change_vector, 8'hE1);
    bus.wake = 1'b0;
    quiet = 0;
    repeat (16) begin
      tick();
      if (bus.ack0 || bus.change) quiet++;
    end
    chk("t5_held_off", quiet, 0);
    tick();
    chk("t5_req_after", st, 6'b100110);
    chk("t5_req_vec", bus.change_vector, 8'h81);
    bus.req0 = 1'b0;
    wait_idle("t5_idle2");

    // 6: reset five cycles into settle
    bus.req0 = 1'b1; bus.vec0 = 8'h81;
    tick();
    chk("t6_grant", st, 6'b100110);
    bus.req0 = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_async_clear", {18'd0, st, bus.change_vector}, 32'd0);
    bus.req0 = 1'b1; bus.vec0 = 8'h22;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t6_idle_after", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("t6_regrant", st, 6'b100110);
    chk("t6_vec", bus.change_vector, 8'h22);
    bus.req0 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
